// File: rtl/sample_serializer.sv
// Serial DAC transmitter: buffers one signed sample and shifts it MSB-first over cs_n/sclk/mosi.
// Define SERIALIZER_OFFSET_BINARY_EN to send offset-binary codes (sample MSB inverted).
module sample_serializer #(
  parameter int N_FRAC  = 7,
  parameter int CLK_DIV = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [N_FRAC:0] data_i,
  input  logic            data_valid_strobe_i,
  output logic            cs_n_o,
  output logic            sclk_o,
  output logic            mosi_o,
  output logic            busy_o,
  output logic            overflow_o
);

  localparam int W     = N_FRAC + 1;
  localparam int DIV_W = $clog2(CLK_DIV + 1);
  localparam int CNT_W = $clog2(W + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(W);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    GAP
  } state_t;

  state_t           state_q, state_d;
  logic [W-1:0]     hold_q, hold_d;
  logic             hold_valid_q, hold_valid_d;
  logic [W-1:0]     shreg_q, shreg_d, shifted, load_word;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             cs_n_d, sclk_d, mosi_d, busy_d, overflow_d;
  logic             consume;

  always_comb begin
`ifdef SERIALIZER_OFFSET_BINARY_EN
    load_word = {~hold_q[W-1], hold_q[W-2:0]};
`else
    load_word = hold_q;
`endif
  end

  assign shifted = shreg_q << 1;

  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    shreg_d      = shreg_q;
    bit_cnt_d    = bit_cnt_q;
    div_d        = div_q;
    cs_n_d       = cs_n_o;
    sclk_d       = sclk_o;
    mosi_d       = mosi_o;
    consume      = 1'b0;

    case (state_q)
      IDLE: begin
        cs_n_d = 1'b1;
        sclk_d = 1'b0;
        if (hold_valid_q) begin
          consume   = 1'b1;
          shreg_d   = load_word;
          cs_n_d    = 1'b0;
          mosi_d    = load_word[W-1];
          bit_cnt_d = CNT_FULL;
          div_d     = '0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        // The divider paces each sclk phase; a bit ends when the high phase expires.
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (!sclk_o) begin
            sclk_d = 1'b1;
          end else begin
            sclk_d    = 1'b0;
            bit_cnt_d = bit_cnt_q - CNT_ONE;
            if (bit_cnt_q > CNT_ONE) begin
              shreg_d = shifted;
              mosi_d  = shifted[W-1];
            end else begin
              cs_n_d  = 1'b1;
              mosi_d  = 1'b0;
              state_d = GAP;
            end
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      GAP: begin
        if (div_q == DIV_LAST) begin
          div_d   = '0;
          state_d = IDLE;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // A strobe during the transfer cycle refills the hold, so it stays valid.
    if (data_valid_strobe_i) begin
      hold_d       = data_i;
      hold_valid_d = 1'b1;
    end else if (consume) begin
      hold_valid_d = 1'b0;
    end

    overflow_d = data_valid_strobe_i && hold_valid_q && !consume;
    busy_d     = (state_d != IDLE) || hold_valid_d;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q      <= IDLE;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      shreg_q      <= '0;
      bit_cnt_q    <= '0;
      div_q        <= '0;
      cs_n_o       <= 1'b1;
      sclk_o       <= 1'b0;
      mosi_o       <= 1'b0;
      busy_o       <= 1'b0;
      overflow_o   <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      shreg_q      <= shreg_d;
      bit_cnt_q    <= bit_cnt_d;
      div_q        <= div_d;
      cs_n_o       <= cs_n_d;
      sclk_o       <= sclk_d;
      mosi_o       <= mosi_d;
      busy_o       <= busy_d;
      overflow_o   <= overflow_d;
    end
  end

endmodule

// File: tb/tb_sample_serializer.sv
// Directed bench for sample_serializer: a pin monitor reassembles frames, and each
// scenario compares them against hand-computed words, lengths and latencies.
module tb_sample_serializer;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b0;
  logic [7:0] data_i = 8'h00;
  logic       data_valid_strobe_i = 1'b0;
  logic       cs_n_o, sclk_o, mosi_o, busy_o, overflow_o;

`ifdef SERIALIZER_OFFSET_BINARY_EN
  localparam logic [7:0] MSB_FLIP = 8'h80;
`else
  localparam logic [7:0] MSB_FLIP = 8'h00;
`endif

  sample_serializer #(.N_FRAC(7), .CLK_DIV(2)) dut (
    .clk_i               (clk_i),
    .rst_i               (rst_i),
    .data_i              (data_i),
    .data_valid_strobe_i (data_valid_strobe_i),
    .cs_n_o              (cs_n_o),
    .sclk_o              (sclk_o),
    .mosi_o              (mosi_o),
    .busy_o              (busy_o),
    .overflow_o          (overflow_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] word;
    int         edges;
    int         len;
    int         start;
  } frame_t;

  frame_t     frames[$];
  logic [7:0] cur_word = 8'h00;
  int         cur_edges = 0;
  int         cur_len = 0;
  int         cur_start = 0;
  logic       prev_cs = 1'b1;
  logic       prev_sclk = 1'b0;
  int         ovf_count = 0;
  int         ovf_cyc = -1;
  int         checks = 0;
  int         errors = 0;

  // Pin-level monitor: a frame is the span of cs_n low; bits are taken on sclk rising.
  always @(negedge clk_i) begin
    if (cs_n_o === 1'b0) begin
      if (prev_cs) begin
        cur_word  = 8'h00;
        cur_edges = 0;
        cur_len   = 0;
        cur_start = cyc;
      end
      cur_len++;
      if (sclk_o === 1'b1 && prev_sclk === 1'b0) begin
        cur_word = {cur_word[6:0], mosi_o};
        cur_edges++;
      end
    end else if (prev_cs === 1'b0) begin
      frames.push_back('{cur_word, cur_edges, cur_len, cur_start});
    end
    if (overflow_o === 1'b1) begin
      ovf_count++;
      ovf_cyc = cyc;
    end
    prev_cs   = (cs_n_o !== 1'b0);
    prev_sclk = (sclk_o === 1'b1);
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic stepCycle();
    @(negedge clk_i);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] d, output int t);
    stepCycle();
    data_i              = d;
    data_valid_strobe_i = 1'b1;
    t                   = cyc;
    stepCycle();
    data_valid_strobe_i = 1'b0;
  endtask

  task automatic waitFrames(input int n, input int budget);
    for (int i = 0; i < budget && frames.size() < n; i++) stepCycle();
    checkOutput("frames_seen", frames.size(), n);
  endtask

  task automatic waitIdle();
    for (int i = 0; i < 200 && (busy_o !== 1'b0 || cs_n_o !== 1'b1); i++) stepCycle();
    repeat (2) stepCycle();
    checkOutput("idle_busy", busy_o, 0);
    frames.delete();
    ovf_count = 0;
    ovf_cyc   = -1;
  endtask

  task automatic checkFrame(input string tag, input int idx, input logic [7:0] word);
    if (idx < frames.size()) begin
      checkOutput({tag, "_word"}, frames[idx].word, word);
      checkOutput({tag, "_edges"}, frames[idx].edges, 8);
      checkOutput({tag, "_len"}, frames[idx].len, 32);
    end else begin
      checkOutput({tag, "_missing"}, frames.size(), idx + 1);
    end
  endtask

  int t0, t1, t2;

  initial begin
    // Reset held with strobes active: outputs quiet, nothing captured.
    rst_i               = 1'b0;
    data_i              = 8'h55;
    data_valid_strobe_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      stepCycle();
      checkOutput("rst_cs_n", cs_n_o, 1);
      checkOutput("rst_sclk", sclk_o, 0);
      checkOutput("rst_mosi", mosi_o, 0);
      checkOutput("rst_busy", busy_o, 0);
      checkOutput("rst_ovf", overflow_o, 0);
    end
    rst_i               = 1'b1;
    data_valid_strobe_i = 1'b0;
    repeat (40) stepCycle();
    checkOutput("rst_no_frame", frames.size(), 0);
    waitIdle();

    // Single frame 0x5A.
    applyStimulus(8'h5A, t0);
    checkOutput("single_busy_rise", busy_o, 1);
    checkOutput("single_cs_not_yet", cs_n_o, 1);
    waitFrames(1, 100);
    checkFrame("single", 0, 8'h5A);
    if (frames.size() > 0) checkOutput("single_latency", frames[0].start - t0, 2);
    waitIdle();

    // Back-to-back: second strobe 5 cycles later is held, not an overflow.
    applyStimulus(8'h81, t0);
    repeat (3) stepCycle();
    applyStimulus(8'h7F, t1);
    checkOutput("b2b_strobe_gap", t1 - t0, 5);
    waitFrames(2, 150);
    checkFrame("b2b_first", 0, 8'h81);
    checkFrame("b2b_second", 1, 8'h7F);
    if (frames.size() > 1) checkOutput("b2b_period", frames[1].start - frames[0].start, 35);
    checkOutput("b2b_no_ovf", ovf_count, 0);
    waitIdle();

    // Overflow: 0x22 is overwritten by 0x33 while 0x11 is shifting.
    applyStimulus(8'h11, t0);
    repeat (2) stepCycle();
    applyStimulus(8'h22, t1);
    repeat (2) stepCycle();
    applyStimulus(8'h33, t2);
    checkOutput("ovf_strobe_gap", t2 - t0, 8);
    waitFrames(2, 150);
    repeat (50) stepCycle();
    checkOutput("ovf_frame_count", frames.size(), 2);
    checkFrame("ovf_first", 0, 8'h11);
    checkFrame("ovf_second", 1, 8'h33);
    checkOutput("ovf_pulses", ovf_count, 1);
    checkOutput("ovf_when", ovf_cyc - t0, 9);
    waitIdle();

    // Reset after the 3rd sclk rising edge aborts the frame for good.
    applyStimulus(8'h5A, t0);
    for (int i = 0; i < 100 && !(cs_n_o === 1'b0 && cur_edges == 3); i++) stepCycle();
    checkOutput("midrst_third_edge", cur_edges, 3);
    rst_i = 1'b0;
    stepCycle();
    checkOutput("midrst_cs_n", cs_n_o, 1);
    checkOutput("midrst_sclk", sclk_o, 0);
    rst_i = 1'b1;
    repeat (60) stepCycle();
    checkOutput("midrst_frames", frames.size(), 1);
    if (frames.size() > 0) checkOutput("midrst_edges", frames[0].edges, 3);
    waitIdle();
    applyStimulus(8'h3C, t0);
    waitFrames(1, 100);
    checkFrame("post_rst", 0, 8'h3C);
    waitIdle();

    // Offset binary (MSB flipped only when the macro is defined).
    applyStimulus(8'h80, t0);
    waitFrames(1, 100);
    checkFrame("code_80", 0, 8'h80 ^ MSB_FLIP);
    waitIdle();
    applyStimulus(8'h00, t0);
    waitFrames(1, 100);
    checkFrame("code_00", 0, 8'h00 ^ MSB_FLIP);
    waitIdle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sample_serializer.md
# sample_serializer

Serial transmitter for the wave generator's output sample stream. It accepts a signed sample on each `data_valid_strobe_i` pulse and buffers one pending sample. It shifts each sample MSB-first to an external serial DAC over a 3-wire SPI-style link (`cs_n_o`, `sclk_o`, `mosi_o`). It sits directly downstream of the wave generator's `data_o` / `data_valid_strobe_o` pair and is the pin-facing end of that stream.

## Interface
Parameters:
- `N_FRAC`, default 7: sample word is `N_FRAC+1` bits, signed.
- `CLK_DIV`, default 2: `sclk_o` half-period in `clk_i` cycles; legal range is 1 or more.

Ports (clock and reset first):
- `clk_i` input 1: single system clock; all logic on its rising edge.
- `rst_i` input 1: reset, synchronous, active-low.
- `data_i` input `N_FRAC+1`: signed sample, sampled only while `data_valid_strobe_i` is 1.
- `data_valid_strobe_i` input 1: one-cycle strobe marking a new sample.
- `cs_n_o` output 1: frame select, active-low.
- `sclk_o` output 1: serial clock, idle low; the DAC samples on the rising edge.
- `mosi_o` output 1: serial data, MSB first.
- `busy_o` output 1: 1 while the FSM is not IDLE or a sample is held.
- `overflow_o` output 1: one-cycle pulse when a held sample is overwritten.

## Operation
Storage:
- Hold register `hold` with flag `hold_valid`.
- Shift register `shreg` of `N_FRAC+1` bits.
- Bit counter and divider counter.
- All outputs are registered.

Hold rules, evaluated each cycle:
- Strobe while `hold_valid`=0: `hold <= data_i`, `hold_valid <= 1`.
- Strobe while `hold_valid`=1 and the hold is not being consumed this cycle: `hold <= data_i` (newest sample wins) and `overflow_o` pulses 1 the next cycle.
- Strobe in the same cycle the hold transfers to `shreg`: `hold <= data_i` and `hold_valid` stays 1. This is not an overflow.

FSM states:
- IDLE:
  - `cs_n_o`=1, `sclk_o`=0.
  - If `hold_valid`: `shreg <= hold`, `hold_valid <= 0`, `cs_n_o <= 0`, `mosi_o <=` MSB of the loaded word, bit counter `<= N_FRAC+1`, divider `<= 0`, go to SHIFT.
- SHIFT:
  - Each bit is `CLK_DIV` cycles with `sclk_o`=0, then `CLK_DIV` cycles with `sclk_o`=1.
  - At the end of each high phase: `sclk_o <= 0` and the bit counter decrements.
  - If bits remain, `mosi_o <=` next bit.
  - After the last bit: `cs_n_o <= 1`, `mosi_o <= 0`, go to GAP.
- GAP: `cs_n_o`=1 for `CLK_DIV` cycles, then go to IDLE.

Reset: `cs_n_o`=1, `sclk_o`=0, `mosi_o`=0, `busy_o`=0, `overflow_o`=0. FSM goes to IDLE, `hold_valid`=0, counters=0.

Reset mid-frame: the frame is aborted on the reset edge and the held sample is discarded. No partial frame resumes.

## Timing
- Strobe in cycle t: the hold is written at the end of t. With the FSM in IDLE, `cs_n_o` is low from cycle t+2, so strobe-to-frame latency is 2 cycles.
- `cs_n_o` low duration: `2*CLK_DIV*(N_FRAC+1)` cycles. Defaults give 32.
- `mosi_o` is stable for the full bit period and changes only while `sclk_o` is low.
- Minimum frame-to-frame period: `(2*(N_FRAC+1)+1)*CLK_DIV + 1` cycles. Defaults give 35, counting the GAP and one IDLE transfer cycle.
- `busy_o` rises the cycle after the strobe. It falls the cycle after GAP exits, provided `hold_valid`=0.

## Configuration
Macro `SERIALIZER_OFFSET_BINARY_EN`:
- Defined: the MSB is inverted when `hold` loads into `shreg`, giving offset-binary DAC code. Examples: -128 becomes 0x00, 0 becomes 0x80, 127 becomes 0xFF.
- Undefined: raw two's complement is transmitted unchanged.

## Test plan
- Reset: hold `rst_i`=0 for 3 cycles with strobes active. Required: `cs_n_o`=1, `sclk_o`=0, `mosi_o`=0, `busy_o`=0, `overflow_o`=0 throughout. No frame follows release.
- Single frame: defaults, macro undefined, strobe 0x5A at cycle t.
  - `cs_n_o` low from t+2 for 32 cycles.
  - Exactly 8 `sclk_o` rising edges.
  - `mosi_o` at each rising edge reads 0,1,0,1,1,0,1,0.
- Back-to-back: strobe 0x81, then 0x7F 5 cycles later. Required: frame 0x81, then the 0x7F frame starts with `cs_n_o` low 35 cycles after the first frame began. `overflow_o` never pulses.
- Overflow: strobes 0x11, 0x22, 0x33 at t, t+4, t+8.
  - `overflow_o` pulses once, at t+9.
  - Transmitted frames are 0x11 then 0x33; 0x22 is never sent.
- Reset mid-frame: apply reset after the 3rd `sclk_o` rising edge of frame 0x5A.
  - `cs_n_o`=1 the next cycle and no further edges.
  - A new strobe 0x3C produces a complete, correct 8-bit frame.
- Offset binary:
  - Macro defined: sample 0x80 shifts out 00000000; sample 0x00 shifts out 10000000.
  - Macro undefined: sample 0x80 shifts out 10000000.
